// File: rtl/cdb_result_buffer.sv
// CDB result buffer: per-FU FIFO presenting its head to the CDB arbiter.
// Optional same-cycle bypass when empty: CDB_RESULT_BUFFER_BYPASS_EN.
module cdb_result_buffer #(
  parameter int DEPTH  = 4,
  parameter int TAG_W  = 6,
  parameter int DATA_W = 32,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int OCC_W = $clog2(DEPTH + 1),
  localparam int ENT_W = TAG_W + DATA_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             fu_result_valid,
  input  logic [ENT_W-1:0] fu_result,
  output logic             fu_result_ready,
  input  logic             flush,
  output logic             cdb_req_valid,
  output logic [ENT_W-1:0] cdb_req_data,
  input  logic             cdb_grant,
  output logic [OCC_W-1:0] occupancy,
  output logic             full,
  output logic             empty
);

  logic [ENT_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [OCC_W-1:0] occ;
  logic             bypass;
  logic             push;
  logic             pop;

  assign full            = (occ == OCC_W'(DEPTH));
  assign empty           = (occ == '0);
  assign occupancy       = occ;
  assign fu_result_ready = !full;

`ifdef CDB_RESULT_BUFFER_BYPASS_EN
  assign bypass = empty && fu_result_valid && !flush;
`else
  assign bypass = 1'b0;
`endif

  // a bypassed result granted this cycle never enters storage
  assign push = fu_result_valid && !full && !flush
              && !(bypass && cdb_grant);
  assign pop  = cdb_grant && !empty && !flush;

  // head presentation; payload is zero whenever nothing is offered
  always_comb begin
    cdb_req_valid = !empty;
    cdb_req_data  = empty ? '0 : mem[rd_ptr];
    if (bypass) begin
      cdb_req_valid = 1'b1;
      cdb_req_data  = fu_result;
    end
  end

  // storage write; contents need no reset
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= fu_result;
    end
  end

  // pointers and occupancy; flush outranks push and pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      unique case ({push, pop})
        2'b10:   occ <= occ + OCC_W'(1);
        2'b01:   occ <= occ - OCC_W'(1);
        default: occ <= occ;
      endcase
    end
  end

  // protocol and bound checks for simulation
  always @(posedge clk) begin
    if (rst_n) begin
      assert (!(cdb_grant && !cdb_req_valid))
        else $error("cdb_grant without cdb_req_valid");
      assert (occ <= OCC_W'(DEPTH))
        else $error("occupancy above DEPTH");
      assert (!(pop && empty))
        else $error("pop from empty buffer");
    end
  end

endmodule
